mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, SHALL set the maximum number of BUSY cycles before forced release (used only with ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req  input  4  request per requester; bit i = requester i.
REQ-005 mem_ack  input  1  shared memory port completes current transaction this cycle.
REQ-006 gnt  output  4  one-hot grant, registered.
REQ-007 sel  output  2  index of granted requester, registered; drives the select of the shared 4:1 datapath mux (00=a, 01=b, 10=c, 11=d).
REQ-008 mem_valid  output  1  equals OR of gnt; transaction in flight.
REQ-009 timeout_err  output  1  one-cycle pulse on forced release; port always present.

Function
REQ-010 FSM SHALL have exactly two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 IDLE with req != 0 SHALL select a winner round-robin, starting the search at index ptr and wrapping 3->0, and enter BUSY with gnt/sel valid on the next edge (1-cycle grant latency).
REQ-012 IDLE with req == 0 SHALL remain IDLE with gnt = 0 and sel unchanged.
REQ-013 BUSY SHALL hold gnt and sel constant until mem_ack = 1, ignoring changes on req, including withdrawal by the granted requester.
REQ-014 On a BUSY cycle with mem_ack = 1, ptr SHALL become (sel + 1) mod 4.
REQ-015 On the same mem_ack cycle, the arbiter SHALL re-arbitrate over (req & ~gnt) from the new ptr: nonzero -> next grant on the next edge with no bubble; zero -> IDLE on the next edge.
REQ-016 The just-served requester SHALL NOT be re-granted on its own ack cycle even if its req is still high; it competes again from the following cycle.
REQ-017 mem_ack in IDLE SHALL be ignored.
REQ-018 gnt SHALL never have more than one bit set; sel SHALL equal the index of the set bit whenever gnt != 0.
REQ-019 With all four requesters continuously requesting, grants SHALL rotate 0,1,2,3,0... and no requester SHALL wait more than 3 transactions.

Reset
REQ-020 rst = 1 on a clock edge SHALL force IDLE, gnt = 0000, sel = 00, ptr = 0, mem_valid = 0, timeout_err = 0 and the timeout counter to 0, overriding any in-flight grant and any simultaneous mem_ack.
REQ-021 The first arbitration after reset release SHALL give priority order 0,1,2,3.

Configuration
REQ-022 Macro ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack.
REQ-023 With ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYC - 1 without mem_ack, the grant SHALL be released exactly as for mem_ack (ptr advance, REQ-015/016 masking) and timeout_err SHALL pulse for one cycle, aligned with gnt changing.
REQ-024 With ARB_TIMEOUT_EN, mem_ack on the same cycle as the timeout SHALL win: normal release and no timeout_err.
REQ-025 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be synthesized, timeout_err SHALL be constant 0, and a grant SHALL be held indefinitely until mem_ack.

Structure
REQ-026 A shared package arb_pkg SHALL hold N_REQ = 4, IDX_W = 2, the state encoding (IDLE, BUSY) and the default TIMEOUT_CYC.
REQ-027 The combinational round-robin search (inputs: 4-bit request vector and 2-bit ptr; outputs: one-hot winner, index, any) SHALL be a separate sub-module rr_pick, instantiated once.
REQ-028 The arbiter SHALL NOT contain the datapath mux; the mux is instantiated by the parent and driven by sel.

Verification
REQ-029 After reset, req = 0110 -> gnt = 0010 and sel = 01 one cycle later; mem_ack pulse with req = 0100 -> gnt = 0100, sel = 10 on the next cycle with no bubble.
REQ-030 req held at 1111 with mem_ack every 2nd BUSY cycle -> sel sequence 00,01,10,11,00; gnt always one-hot.
REQ-031 req = 0001 held high through ack -> one IDLE cycle (gnt = 0000), then gnt = 0001 again.
REQ-032 Granted requester drops req mid-BUSY, and mem_ack arrives 5 cycles later -> gnt held for all 5 cycles, then released.
REQ-033 With ARB_TIMEOUT_EN and TIMEOUT_CYC = 4, req = 1000 and no ack -> gnt released after 4 BUSY cycles, timeout_err = 1 for exactly one cycle; ack on the 4th cycle -> timeout_err stays 0.
REQ-034 rst asserted mid-BUSY together with mem_ack -> next cycle gnt = 0000, sel = 00, timeout_err = 0; with req = 1111 after release, the first grant goes to 0001.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the memory-port arbiter.
package arb_pkg;
    localparam int N_REQ           = 4;
    localparam int IDX_W           = 2;
    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between requesters/memory port (master) and the arbiter (slave).
interface mem_port_arbiter_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             mem_ack;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] sel;
    logic             mem_valid;
    logic             timeout_err;

    modport master (
        output req, mem_ack,
        input  gnt, sel, mem_valid, timeout_err
    );

    modport slave (
        input  req, mem_ack,
        output gnt, sel, mem_valid, timeout_err
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping 3->0.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);
    // rot[k] is the request k positions after ptr, so a fixed priority search on rot
    // is a round-robin search on req_vec.
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = req_vec[ptr + IDX_W'(gi)];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign win_any = |req_vec;
    assign win_idx = ptr + off;
    assign win_oh  = win_any ? (N_REQ'(1) << win_idx) : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one shared memory port; grant held until mem_ack.
// Optional watchdog release enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    state_t           state_reg, state_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0] sel_reg, sel_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;

    logic             timeout_hit;
    logic             release_now;
    logic [N_REQ-1:0] pick_req;
    logic [IDX_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    // While busy, the search runs over the other requesters from the advanced pointer,
    // so a release hands over without a bubble and never re-grants the served one.
    assign release_now = (state_reg == BUSY) && (bus.mem_ack || timeout_hit);
    assign pick_req    = (state_reg == BUSY) ? (bus.req & ~gnt_reg) : bus.req;
    assign pick_ptr    = (state_reg == BUSY) ? (sel_reg + IDX_W'(1)) : ptr_reg;

    rr_pick u_rr_pick (
        .req_vec (pick_req),
        .ptr     (pick_ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_any (pick_any)
    );

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next = BUSY;
                    gnt_next   = pick_oh;
                    sel_next   = pick_idx;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_next = sel_reg + IDX_W'(1);
                    if (pick_any) begin
                        gnt_next = pick_oh;
                        sel_next = pick_idx;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            sel_reg   <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             terr_reg;

    // mem_ack on the limit cycle takes precedence, so the hit requires no ack.
    assign timeout_hit = (state_reg == BUSY) && !bus.mem_ack
                         && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_next = cnt_reg;
        if ((state_next == BUSY) && ((state_reg == IDLE) || release_now)) begin
            cnt_next = '0;
        end else if (state_reg == BUSY) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            terr_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            terr_reg <= timeout_hit;
        end
    end

    assign bus.timeout_err = terr_reg;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign bus.timeout_err    = 1'b0;
`endif

    assign bus.gnt       = gnt_reg;
    assign bus.sel       = sel_reg;
    assign bus.mem_valid = |gnt_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grant state queued per step, checked after the edge.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       terr;
        string      tag;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_failed;
    exp_t sb_q[$];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s %s: observed %b expected %b", tag, name, obs, exp);
        end
    endtask

    task automatic check_vec(input string name, input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s %s: observed %b expected %b", tag, name, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue what must be visible after the edge, then compare.
    task automatic step(input logic r, input logic [3:0] rq, input logic ack,
                        input logic [3:0] eg, input logic [1:0] es, input logic et,
                        input string tag);
        exp_t e;
        rst         = r;
        bus.req     = rq;
        bus.mem_ack = ack;
        e.gnt  = eg;
        e.sel  = es;
        e.terr = et;
        e.tag  = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        $display("[TB] %-10s rst=%b req=%b ack=%b -> gnt=%b sel=%b valid=%b terr=%b",
                 e.tag, r, rq, ack, bus.gnt, bus.sel, bus.mem_valid, bus.timeout_err);
        check_vec("gnt", e.tag, bus.gnt, e.gnt);
        check_vec("sel", e.tag, {2'b00, bus.sel}, {2'b00, e.sel});
        check_bit("mem_valid", e.tag, bus.mem_valid, |e.gnt);
        check_bit("timeout_err", e.tag, bus.timeout_err, e.terr);
        check_bit("onehot", e.tag, $onehot0(bus.gnt), 1'b1);
    endtask

    initial begin
        n_tests     = 0;
        n_failed    = 0;
        rst         = 1'b1;
        bus.req     = '0;
        bus.mem_ack = 1'b0;
        @(negedge clk);

        // Reset state, then back-to-back handover without a bubble
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "reset");
        step(0, 4'b0110, 0, 4'b0010, 2'd1, 0, "grant_b");
        step(0, 4'b0100, 1, 4'b0100, 2'd2, 0, "handover");
        step(0, 4'b0000, 1, 4'b0000, 2'd2, 0, "to_idle");
        step(0, 4'b0000, 1, 4'b0000, 2'd2, 0, "idle_ack");

        // Full load with ack every second busy cycle: strict rotation
        step(1, 4'b0000, 0, 4'b0000, 2'd0, 0, "reset2");
        step(0, 4'b1111, 0, 4'b0001, 2'd0, 0, "rot0");
        step(0, 4'b1111, 0, 4'b0001, 2'd0, 0, "rot0_hold");
        step(0, 4'b1111, 1, 4'b0010, 2'd1, 0, "rot1");
        step(0, 4'b1111, 0, 4'b0010, 2'd1, 0, "rot1_hold");
        step(0, 4'b1111, 1, 4'b0100, 2'd2, 0, "rot2");
        step(0, 4'b1111, 0, 4'b0100, 2'd2, 0, "rot2_hold");
        step(0, 4'b1111, 1, 4'b1000, 2'd3, 0, "rot3");
        step(0, 4'b1111, 0, 4'b1000, 2'd3, 0, "rot3_hold");
        step(0, 4'b1111, 1, 4'b0001, 2'd0, 0, "rot0_again");
        step(0, 4'b0000, 1, 4'b0000, 2'd0, 0, "rot_idle");

        // Sole requester stays high through its ack: one idle cycle, then regrant
        step(0, 4'b0001, 0, 4'b0001, 2'd0, 0, "solo_gnt");
        step(0, 4'b0001, 1, 4'b0000, 2'd0, 0, "solo_mask");
        step(0, 4'b0001, 0, 4'b0001, 2'd0, 0, "solo_regnt");
        step(0, 4'b0000, 1, 4'b0000, 2'd0, 0, "solo_idle");

        // Granted requester withdraws; grant held regardless of req until ack
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "hold_gnt");
        step(0, 4'b0000, 0, 4'b0100, 2'd2, 0, "hold1");
        step(0, 4'b0000, 0, 4'b0100, 2'd2, 0, "hold2");
        step(0, 4'b1011, 0, 4'b0100, 2'd2, 0, "hold3");
        step(0, 4'b0000, 0, 4'b0100, 2'd2, 0, "hold4");
        step(0, 4'b0000, 0, 4'b0100, 2'd2, 0, "hold5");
        step(0, 4'b0000, 1, 4'b0000, 2'd2, 0, "hold_rel");

        // Reset with simultaneous ack mid-busy: pointer must restart at 0
        step(0, 4'b1111, 0, 4'b1000, 2'd3, 0, "pre_rst");
        step(1, 4'b1111, 1, 4'b0000, 2'd0, 0, "rst_busy");
        step(0, 4'b1111, 0, 4'b0001, 2'd0, 0, "post_rst");
        step(0, 4'b0000, 1, 4'b0000, 2'd0, 0, "post_idle");

`ifdef ARB_TIMEOUT_EN
        // Forced release after four busy cycles, one-cycle error pulse
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 0, "to_gnt");
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 0, "to_b2");
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 0, "to_b3");
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 0, "to_b4");
        step(0, 4'b1000, 0, 4'b0000, 2'd3, 1, "to_fire");
        step(0, 4'b0000, 0, 4'b0000, 2'd3, 0, "to_clear");
        // Ack on the limit cycle wins: no error
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 0, "ak_gnt");
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 0, "ak_b2");
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 0, "ak_b3");
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 0, "ak_b4");
        step(0, 4'b0000, 1, 4'b0000, 2'd3, 0, "ak_rel");
        step(0, 4'b0000, 0, 4'b0000, 2'd3, 0, "ak_quiet");
`else
        // Without the watchdog a grant outlives any timeout setting
        step(0, 4'b1000, 0, 4'b1000, 2'd3, 0, "nto_gnt");
        for (int i = 0; i < 12; i++) begin
            step(0, 4'b1000, 0, 4'b1000, 2'd3, 0, "nto_hold");
        end
        step(0, 4'b0000, 1, 4'b0000, 2'd3, 0, "nto_rel");
`endif

        n_tests++;
        assert (sb_q.size() == 0) else begin
            n_failed++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
